// File: rtl/id_ex_register_if.sv
// ID/EX pipeline register bus: ID-stage fields in, EX-stage fields and load-use hazard out.
interface id_ex_register_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned FUNCT_W = 10;
    localparam int unsigned ADDR_W  = 5;

    logic               stall_i;
    logic               flush_i;
    logic               valid_i;
    logic               RegWrite_i;
    logic               MemToReg_i;
    logic               MemRead_i;
    logic               MemWrite_i;
    logic               ALUSrc_i;
    logic               Branch_i;
    logic [1:0]         ALUOp_i;
    logic [XLEN-1:0]    pc_i;
    logic [XLEN-1:0]    rs1_data_i;
    logic [XLEN-1:0]    rs2_data_i;
    logic [XLEN-1:0]    imm_i;
    logic [FUNCT_W-1:0] funct_i;
    logic [ADDR_W-1:0]  rs1_addr_i;
    logic [ADDR_W-1:0]  rs2_addr_i;
    logic [ADDR_W-1:0]  rd_addr_i;

    logic               valid_o;
    logic               RegWrite_o;
    logic               MemToReg_o;
    logic               MemRead_o;
    logic               MemWrite_o;
    logic               ALUSrc_o;
    logic               Branch_o;
    logic [1:0]         ALUOp_o;
    logic [XLEN-1:0]    pc_o;
    logic [XLEN-1:0]    rs1_data_o;
    logic [XLEN-1:0]    rs2_data_o;
    logic [XLEN-1:0]    imm_o;
    logic [FUNCT_W-1:0] funct_o;
    logic [ADDR_W-1:0]  rs1_addr_o;
    logic [ADDR_W-1:0]  rs2_addr_o;
    logic [ADDR_W-1:0]  rd_addr_o;
    logic               hazard_o;

    modport master (
        output stall_i, flush_i, valid_i,
        output RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i, ALUOp_i,
        output pc_i, rs1_data_i, rs2_data_i, imm_i, funct_i,
        output rs1_addr_i, rs2_addr_i, rd_addr_i,
        input  valid_o,
        input  RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o, ALUOp_o,
        input  pc_o, rs1_data_o, rs2_data_o, imm_o, funct_o,
        input  rs1_addr_o, rs2_addr_o, rd_addr_o,
        input  hazard_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i,
        input  RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i, ALUOp_i,
        input  pc_i, rs1_data_i, rs2_data_i, imm_i, funct_i,
        input  rs1_addr_i, rs2_addr_i, rd_addr_i,
        output valid_o,
        output RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o, ALUOp_o,
        output pc_o, rs1_data_o, rs2_data_o, imm_o, funct_o,
        output rs1_addr_o, rs2_addr_o, rd_addr_o,
        output hazard_o
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall/flush and load-use hazard detection.
module id_ex_register (
    input logic                clk_i,
    input logic                rst_i,
    id_ex_register_if.slave    bus
);

    // Reset and flush both leave a fully zeroed bubble, so they share one branch.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            bus.valid_o    <= 1'b0;
            bus.RegWrite_o <= 1'b0;
            bus.MemToReg_o <= 1'b0;
            bus.MemRead_o  <= 1'b0;
            bus.MemWrite_o <= 1'b0;
            bus.ALUSrc_o   <= 1'b0;
            bus.Branch_o   <= 1'b0;
            bus.ALUOp_o    <= '0;
            bus.pc_o       <= '0;
            bus.rs1_data_o <= '0;
            bus.rs2_data_o <= '0;
            bus.imm_o      <= '0;
            bus.funct_o    <= '0;
            bus.rs1_addr_o <= '0;
            bus.rs2_addr_o <= '0;
            bus.rd_addr_o  <= '0;
        end else if (!bus.stall_i) begin
            // Side-effecting controls of an invalid slot are dropped on capture.
            bus.valid_o    <= bus.valid_i;
            bus.RegWrite_o <= bus.RegWrite_i & bus.valid_i;
            bus.MemToReg_o <= bus.MemToReg_i;
            bus.MemRead_o  <= bus.MemRead_i & bus.valid_i;
            bus.MemWrite_o <= bus.MemWrite_i & bus.valid_i;
            bus.ALUSrc_o   <= bus.ALUSrc_i;
            bus.Branch_o   <= bus.Branch_i & bus.valid_i;
            bus.ALUOp_o    <= bus.ALUOp_i;
            bus.pc_o       <= bus.pc_i;
            bus.rs1_data_o <= bus.rs1_data_i;
            bus.rs2_data_o <= bus.rs2_data_i;
            bus.imm_o      <= bus.imm_i;
            bus.funct_o    <= bus.funct_i;
            bus.rs1_addr_o <= bus.rs1_addr_i;
            bus.rs2_addr_o <= bus.rs2_addr_i;
            bus.rd_addr_o  <= bus.rd_addr_i;
        end
    end

    // EX-stage load against the live ID-stage sources; x0 never hazards.
    assign bus.hazard_o = bus.valid_o & bus.MemRead_o & (bus.rd_addr_o != 5'd0)
                        & ((bus.rd_addr_o == bus.rs1_addr_i) | (bus.rd_addr_o == bus.rs2_addr_i));

endmodule

// File: tb/tb_id_ex_register.sv
// Randomized self-checking bench for id_ex_register against a field-record reference model.
module tb_id_ex_register;

    typedef struct packed {
        logic        valid;
        logic        rw, mtr, mr, mw, as, br;
        logic [1:0]  aluop;
        logic [31:0] pc, d1, d2, imm;
        logic [9:0]  funct;
        logic [4:0]  a1, a2, rd;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_register_if #(.XLEN(32)) bus ();
    id_ex_register dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int   total = 0;
    int   bad   = 0;
    rec_t model;
    rec_t cur_in;
    bit   cur_r, cur_f, cur_s;

    // Expected register contents after one edge, from the update priority rules.
    function automatic rec_t next_model(rec_t cur, rec_t in, bit r, bit f, bit s);
        rec_t n;
        if (r || f) return '0;
        if (s) return cur;
        n = in;
        if (!in.valid) begin
            n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.br = 1'b0;
        end
        return n;
    endfunction

    function automatic bit exp_hazard(rec_t ex, rec_t id);
        return ex.valid && ex.mr && (ex.rd != 5'd0) && (ex.rd == id.a1 || ex.rd == id.a2);
    endfunction

    function automatic rec_t rand_rec(int unsigned amax);
        rec_t r;
        r.valid = 1'($urandom); r.rw = 1'($urandom); r.mtr = 1'($urandom);
        r.mr = 1'($urandom); r.mw = 1'($urandom); r.as = 1'($urandom);
        r.br = 1'($urandom); r.aluop = 2'($urandom);
        r.pc = $urandom; r.d1 = $urandom; r.d2 = $urandom; r.imm = $urandom;
        r.funct = 10'($urandom);
        r.a1 = 5'($urandom_range(amax)); r.a2 = 5'($urandom_range(amax));
        r.rd = 5'($urandom_range(amax));
        return r;
    endfunction

    function automatic rec_t dut_rec();
        rec_t r;
        r.valid = bus.valid_o; r.rw = bus.RegWrite_o; r.mtr = bus.MemToReg_o;
        r.mr = bus.MemRead_o; r.mw = bus.MemWrite_o; r.as = bus.ALUSrc_o;
        r.br = bus.Branch_o; r.aluop = bus.ALUOp_o;
        r.pc = bus.pc_o; r.d1 = bus.rs1_data_o; r.d2 = bus.rs2_data_o; r.imm = bus.imm_o;
        r.funct = bus.funct_o; r.a1 = bus.rs1_addr_o; r.a2 = bus.rs2_addr_o; r.rd = bus.rd_addr_o;
        return r;
    endfunction

    task automatic apply(rec_t in, bit r, bit f, bit s);
        bus.valid_i = in.valid; bus.RegWrite_i = in.rw; bus.MemToReg_i = in.mtr;
        bus.MemRead_i = in.mr; bus.MemWrite_i = in.mw; bus.ALUSrc_i = in.as;
        bus.Branch_i = in.br; bus.ALUOp_i = in.aluop;
        bus.pc_i = in.pc; bus.rs1_data_i = in.d1; bus.rs2_data_i = in.d2; bus.imm_i = in.imm;
        bus.funct_i = in.funct; bus.rs1_addr_i = in.a1; bus.rs2_addr_i = in.a2; bus.rd_addr_i = in.rd;
        rst = r; bus.flush_i = f; bus.stall_i = s;
        cur_in = in; cur_r = r; cur_f = f; cur_s = s;
        #1;
    endtask

    task automatic step();
        rec_t n;
        n = next_model(model, cur_in, cur_r, cur_f, cur_s);
        @(posedge clk);
        #1;
        model = n;
    endtask

    task automatic test_reset();
        rec_t obs;
        for (int i = 0; i < 2; i++) begin
            apply(rand_rec(31) | rec_t'(1), 1'b1, 1'b0, 1'b0);
            step();
            obs = dut_rec();
            total++;
            if (obs !== rec_t'(0)) begin
                bad++; $display("FAIL reset_fields: got %h want 0", obs);
            end
            total++;
            if (bus.hazard_o !== 1'b0) begin
                bad++; $display("FAIL reset_hazard: got %b want 0", bus.hazard_o);
            end
        end
    endtask

    task automatic test_pass_through();
        rec_t in, obs;
        in = '0;
        in.valid = 1'b1; in.rw = 1'b1; in.aluop = 2'b00; in.d1 = 32'h1234;
        in.d2 = 32'h0000_5678; in.pc = 32'h0000_0040; in.funct = 10'h020;
        in.a1 = 5'd1; in.a2 = 5'd2; in.rd = 5'd5;
        apply(in, 1'b0, 1'b0, 1'b0);
        step();
        obs = dut_rec();
        total++;
        if (obs !== in) begin
            bad++; $display("FAIL rtype_pass: got %h want %h", obs, in);
        end
        for (int i = 0; i < 20; i++) begin
            apply(rand_rec(31), 1'b0, 1'b0, 1'b0);
            step();
            obs = dut_rec();
            total++;
            if (obs !== model) begin
                bad++; $display("FAIL pass_rand%0d: got %h want %h", i, obs, model);
            end
        end
    endtask

    task automatic test_load_use();
        rec_t lw, id, obs;
        for (int k = 0; k < 2; k++) begin
            lw = '0;
            lw.valid = 1'b1; lw.mr = 1'b1; lw.mtr = 1'b1; lw.rw = 1'b1; lw.as = 1'b1;
            lw.imm = 32'd8; lw.a1 = 5'd10; lw.rd = (k == 0) ? 5'd3 : 5'd0;
            apply(lw, 1'b0, 1'b0, 1'b0);
            step();
            id = rand_rec(31);
            id.valid = 1'b1; id.a1 = 5'd7; id.a2 = (k == 0) ? 5'd3 : 5'd0;
            apply(id, 1'b0, 1'b0, 1'b0);
            total++;
            if (bus.hazard_o !== (k == 0)) begin
                bad++; $display("FAIL loaduse_hz rd%0d: got %b want %b", lw.rd, bus.hazard_o, k == 0);
            end
            id.rw = 1'b0; id.mtr = 1'b0; id.mr = 1'b0; id.mw = 1'b0;
            id.as = 1'b0; id.br = 1'b0; id.aluop = 2'b00;
            apply(id, 1'b0, 1'b0, 1'b0);
            step();
            total++;
            if (bus.MemRead_o !== 1'b0 || bus.hazard_o !== 1'b0) begin
                bad++; $display("FAIL loaduse_bubble: got mr=%b hz=%b want 0 0", bus.MemRead_o, bus.hazard_o);
            end
        end
    endtask

    task automatic test_stall();
        rec_t saved, obs;
        apply(rand_rec(31), 1'b0, 1'b0, 1'b0);
        step();
        saved = model;
        for (int i = 0; i < 3; i++) begin
            apply(rand_rec(31), 1'b0, 1'b0, 1'b1);
            step();
            obs = dut_rec();
            total++;
            if (obs !== saved) begin
                bad++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, saved);
            end
        end
        apply(rand_rec(31), 1'b0, 1'b0, 1'b0);
        step();
        obs = dut_rec();
        total++;
        if (obs !== model) begin
            bad++; $display("FAIL stall_release: got %h want %h", obs, model);
        end
        apply(rand_rec(31), 1'b1, 1'b0, 1'b1);
        step();
        obs = dut_rec();
        total++;
        if (obs !== rec_t'(0)) begin
            bad++; $display("FAIL rst_mid_stall: got %h want 0", obs);
        end
    endtask

    task automatic test_flush_stall();
        rec_t st, obs;
        st = rand_rec(31);
        st.valid = 1'b1; st.mw = 1'b1; st.mr = 1'b0;
        apply(st, 1'b0, 1'b0, 1'b0);
        step();
        total++;
        if (bus.MemWrite_o !== 1'b1) begin
            bad++; $display("FAIL store_load: got mw=%b want 1", bus.MemWrite_o);
        end
        apply(st, 1'b0, 1'b1, 1'b1);
        step();
        obs = dut_rec();
        total++;
        if (obs !== rec_t'(0)) begin
            bad++; $display("FAIL flush_over_stall: got %h want 0", obs);
        end
    endtask

    task automatic test_invalid_slot();
        rec_t in, obs;
        in = rand_rec(31);
        in.valid = 1'b0; in.rw = 1'b1; in.mw = 1'b1; in.mr = 1'b1; in.br = 1'b1;
        apply(in, 1'b0, 1'b0, 1'b0);
        step();
        obs = dut_rec();
        total++;
        if (obs.rw !== 1'b0 || obs.mw !== 1'b0 || obs.valid !== 1'b0 || obs.mr !== 1'b0 || obs.br !== 1'b0) begin
            bad++; $display("FAIL invalid_ctrl: got v=%b rw=%b mw=%b mr=%b br=%b want 0", obs.valid, obs.rw, obs.mw, obs.mr, obs.br);
        end
        total++;
        if (obs !== model) begin
            bad++; $display("FAIL invalid_fields: got %h want %h", obs, model);
        end
    endtask

    task automatic test_random_mix();
        rec_t obs;
        bit r, f, s;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(31) == 0);
            f = ($urandom_range(7) == 0);
            s = ($urandom_range(3) == 0);
            apply(rand_rec(3), r, f, s);
            total++;
            if (bus.hazard_o !== exp_hazard(model, cur_in)) begin
                bad++; $display("FAIL mix_hz%0d: got %b want %b", i, bus.hazard_o, exp_hazard(model, cur_in));
            end
            step();
            obs = dut_rec();
            total++;
            if (obs !== model) begin
                bad++; $display("FAIL mix_fields%0d: got %h want %h", i, obs, model);
            end
        end
    endtask

    initial begin
        model = '0;
        apply('0, 1'b1, 1'b0, 1'b0);
        test_reset();
        test_pass_through();
        test_load_use();
        test_stall();
        test_flush_stall();
        test_invalid_slot();
        test_random_mix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

Pipeline register between the decode stage (Control, register file, immediate generator) and the execute stage of the 5-stage RISC-V core. It captures the decoded control bundle, operand data, immediate, funct bits and register addresses each cycle, and supports stall (hold) and flush (bubble). It also produces the load-use hazard flag that drives Control's No_op input and the PC/IF-ID stall.

## Interface
- XLEN, 32, data/PC width
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  hold all stored fields
- flush_i  in  1  insert bubble (branch taken / redirect)
- valid_i  in  1  ID stage holds a real instruction
- RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i  in  1 each  control bits from Control
- ALUOp_i  in  2  ALU op class from Control
- pc_i, rs1_data_i, rs2_data_i, imm_i  in  XLEN each  ID-stage values
- funct_i  in  10  {funct7, funct3}
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  register indices of the ID-stage instruction
- Matching `_o` outputs for every field above (same widths), plus valid_o  out  1
- hazard_o  out  1  load-use hazard, combinational

## Operation
- Stored fields: valid, 7 control bits incl. ALUOp, pc, rs1/rs2 data, imm, funct, rs1/rs2/rd addr. All outputs driven straight from registers except hazard_o.
- Update priority per rising edge: rst_i > flush_i > stall_i > load.
  - rst_i=1: every stored field <- 0.
  - flush_i=1: valid and all control bits (incl. ALUOp) <- 0; data, pc, imm, funct, addresses <- 0 as well (deterministic bubble).
  - stall_i=1 (no flush): all fields hold.
  - else: all fields <- corresponding inputs; valid <- valid_i.
- valid_i=0 on load: control bits still captured from inputs, but RegWrite_o, MemRead_o, MemWrite_o, Branch_o are forced 0 when stored (no side effects from an invalid slot).
- hazard_o = valid_o & MemRead_o & (rd_addr_o != 0) & ((rd_addr_o == rs1_addr_i) | (rd_addr_o == rs2_addr_i)).
  - Compares the registered EX-stage load against the live ID-stage source indices.
  - Not gated by valid_i; upstream uses it to assert Control's No_op and stall PC/IF-ID for one cycle.
- hazard_o does not drive stall_i internally; the top level wires hazard_o into the upstream stall and No_op, not into this block's stall_i. The resulting ID-stage control zeros enter this register as a bubble on the next edge.
- x0 destination never raises a hazard.

## Timing
- Latency: 1 cycle, ID inputs at edge N appear on outputs after edge N.
- Reset values: all outputs 0, hazard_o 0 (valid_o=0 forces it).
- flush_i and stall_i both high: flush wins, bubble inserted.
- rst_i mid-stall or mid-flush: reset wins, all zero next cycle.
- Stall held K cycles: outputs constant K cycles, hazard_o may change only as rs*_addr_i change.
- hazard_o asserts in the same cycle the load occupies EX; deasserts after the next edge once the bubble is loaded (MemRead_o=0).

## Test plan
- Reset: rst_i=1 for 2 cycles with nonzero inputs -> all outputs 0, valid_o=0, hazard_o=0.
- Pass-through: load R-type (RegWrite=1, ALUOp=00, rs1_data=0x1234, rd=5) -> next cycle outputs match exactly, valid_o=1.
- Load-use: EX holds lw rd=3 (MemRead=1), ID rs2_addr_i=3 -> hazard_o=1 same cycle. Next edge loads zero controls -> MemRead_o=0, hazard_o=0. Repeat with rd=0 -> hazard_o stays 0.
- Stall: stall_i=1 for 3 cycles while inputs toggle -> outputs frozen. Release -> new values after one edge.
- Flush vs stall: flush_i=1 and stall_i=1 together with a valid store -> next cycle MemWrite_o=0, valid_o=0, all data 0.
- Invalid slot: valid_i=0 with RegWrite_i=1, MemWrite_i=1 -> RegWrite_o=0, MemWrite_o=0, valid_o=0.
